// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor (package serial_sub_pkg).
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if #(
    parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, borrow_out, ovf);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, borrow_out);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational full-subtractor bit: two half-subtractor stages whose borrows are ORed.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d1_s;
    logic b1_s;
    logic b2_s;

    // First stage x - y, second stage subtracts the incoming borrow
    assign d1_s = x ^ y;
    assign b1_s = ~x & y;
    assign d    = d1_s ^ bin;
    assign b2_s = ~d1_s & bin;
    assign bout = b1_s | b2_s;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor diff = a - b, LSB first, one bit per clock, reusing one fs_cell.
// Optional SERIAL_SUB_OVF_EN adds a two's-complement overflow output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic               clk,
    input logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] diff_sr_r;
    logic             bor_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             d_s;
    logic             nbor_s;
    logic [WIDTH-1:0] diff_next_s;

    fs_cell u_fs_cell (
        .x    (a_sr_r[0]),
        .y    (b_sr_r[0]),
        .bin  (bor_r),
        .d    (d_s),
        .bout (nbor_s)
    );

    assign diff_next_s = {d_s, diff_sr_r[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_r;
    logic b_msb_r;
    logic ovf_r;

    // Operand sign bits are kept at start; ovf is published with the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (state_r == IDLE && bus.start) begin
            a_msb_r <= bus.a[WIDTH-1];
            b_msb_r <= bus.b[WIDTH-1];
        end else if (state_r == SHIFT && cnt_r == LAST_CNT) begin
            ovf_r <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ d_s);
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign bus.ovf = ovf_r;
`endif

    // Control FSM with datapath shift registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            a_sr_r    <= '0;
            b_sr_r    <= '0;
            diff_sr_r <= '0;
            bor_r     <= 1'b0;
            cnt_r     <= '0;
            diff_r    <= '0;
            borrow_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sr_r  <= bus.a;
                        b_sr_r  <= bus.b;
                        bor_r   <= 1'b0;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr_r    <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r    <= {1'b0, b_sr_r[WIDTH-1:1]};
                    diff_sr_r <= diff_next_s;
                    bor_r     <= nbor_s;
                    cnt_r     <= cnt_r + CNT_W'(1);
                    // The final bit publishes the whole result in the same edge
                    if (cnt_r == LAST_CNT) begin
                        diff_r   <= diff_next_s;
                        borrow_r <= nbor_s;
                        done_r   <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        state_r  <= SHIFT;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.diff       = diff_r;
    assign bus.borrow_out = borrow_r;
endmodule
